// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared op codes, FSM state encoding and op-class helpers for
//               the multi-cycle ALU (alu_core / alu_seq).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int c_op_w = 4;

   typedef enum logic [c_op_w-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_NOT  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_EQ   = 4'd7,
      ALU_SLTU = 4'd8,
      ALU_SLL  = 4'd9,
      ALU_SRL  = 4'd10,
      ALU_SRA  = 4'd11,
      ALU_MUL  = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Shifts iterate one bit per cycle in the sequencer.
   function automatic logic is_shift(input logic [c_op_w-1:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational single-cycle ALU ops (add/sub, logic, compare)
//               with flag generation. Shift, multiply and illegal codes
//               produce result 0 and all flags 0 here.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [c_op_w-1:0] op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              cin,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              overflow,
   output logic              carry,
   output logic              less
);

   logic [WIDTH-1:0] w_b_add;
   logic             w_cin_add;
   logic [WIDTH:0]   w_sum;
   logic             w_slt;
   logic             w_sltu;
   logic             w_eq;
   logic             w_legal;

   // One shared adder serves ADD and SUB; SUB feeds ~b with carry-in 1.
   always_comb begin
      w_b_add   = (op == ALU_SUB) ? ~b : b;
      w_cin_add = (op == ALU_SUB) ? 1'b1 : cin;
      w_sum     = {1'b0, a} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, w_cin_add};
      w_slt     = $signed(a) < $signed(b);
      w_sltu    = a < b;
      w_eq      = (a == b);

      result   = '0;
      overflow = 1'b0;
      carry    = 1'b0;
      less     = 1'b0;
      w_legal  = 1'b1;

      case (op)
         ALU_ADD, ALU_SUB: begin
            result   = w_sum[WIDTH-1:0];
            carry    = w_sum[WIDTH];
            // Overflow uses the operand signs as the adder sees them.
            overflow = (a[WIDTH-1] == w_b_add[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != a[WIDTH-1]);
            less     = (op == ALU_SUB) ? w_slt : 1'b0;
         end
         ALU_NOT:  result = ~a;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLT: begin
            result = {{(WIDTH-1){1'b0}}, w_slt};
            less   = w_slt;
         end
         ALU_EQ: begin
            result = {{(WIDTH-1){1'b0}}, w_eq};
            less   = w_eq;
         end
         ALU_SLTU: begin
            result = {{(WIDTH-1){1'b0}}, w_sltu};
            less   = w_sltu;
         end
         default: w_legal = 1'b0;
      endcase

      // Illegal codes report zero=0 even though the result is 0.
      zero = w_legal && (result == '0);
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle WIDTH-bit ALU with valid/ready handshakes.
//               Single-cycle ops go through alu_core; shifts iterate one bit
//               per cycle and MUL is an iterative shift-add. Result and
//               flags are registered and held in DONE until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [c_op_w-1:0] op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              overflow,
   output logic              carry,
   output logic              less
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;   // counter must hold WIDTH for MUL
   localparam logic [CW-1:0] c_cnt_one   = CW'(1);
   localparam logic [CW-1:0] c_cnt_width = CW'(WIDTH);

   alu_state_e        state_q, state_d;
   logic [c_op_w-1:0] op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;     // shift operand / multiplier
   logic [WIDTH-1:0]  mcand_q, mcand_d;   // multiplicand, consumed LSB first
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              zero_q, zero_d;
   logic              overflow_q, overflow_d;
   logic              carry_q, carry_d;
   logic              less_q, less_d;

   logic [WIDTH-1:0]  w_core_result;
   logic              w_core_zero;
   logic              w_core_overflow;
   logic              w_core_carry;
   logic              w_core_less;
   logic [SW-1:0]     w_amount;
   logic [WIDTH-1:0]  w_step;             // operand/accumulator after this edge

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op       (op),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .result   (w_core_result),
      .zero     (w_core_zero),
      .overflow (w_core_overflow),
      .carry    (w_core_carry),
      .less     (w_core_less)
   );

   assign w_amount  = b[SW-1:0];
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign carry     = carry_q;
   assign less      = less_q;

   // Next-state, iteration and output-register logic.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      opnd_d     = opnd_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      carry_d    = carry_q;
      less_d     = less_q;
      w_step     = '0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d = op;
               if (is_shift(op)) begin
                  if (w_amount == '0) begin
                     result_d   = a;
                     zero_d     = (a == '0);
                     overflow_d = 1'b0;
                     carry_d    = 1'b0;
                     less_d     = 1'b0;
                     state_d    = DONE;
                  end else begin
                     opnd_d  = a;
                     cnt_d   = {1'b0, w_amount};
                     state_d = BUSY;
                  end
               end else if (op == ALU_MUL) begin
                  opnd_d  = a;
                  mcand_d = b;
                  acc_d   = '0;
                  cnt_d   = c_cnt_width;
                  state_d = BUSY;
               end else begin
                  result_d   = w_core_result;
                  zero_d     = w_core_zero;
                  overflow_d = w_core_overflow;
                  carry_d    = w_core_carry;
                  less_d     = w_core_less;
                  state_d    = DONE;
               end
            end
         end

         BUSY: begin
            cnt_d = cnt_q - c_cnt_one;
            if (op_q == ALU_MUL) begin
               w_step  = acc_q + (mcand_q[0] ? opnd_q : '0);
               acc_d   = w_step;
               opnd_d  = opnd_q << 1;
               mcand_d = mcand_q >> 1;
            end else begin
               case (op_q)
                  ALU_SLL: w_step = opnd_q << 1;
                  ALU_SRL: w_step = opnd_q >> 1;
                  default: w_step = {opnd_q[WIDTH-1], opnd_q[WIDTH-1:1]};
               endcase
               opnd_d = w_step;
            end
            if (cnt_q == c_cnt_one) begin
               result_d   = w_step;
               zero_d     = (w_step == '0);
               overflow_d = 1'b0;
               carry_d    = 1'b0;
               less_d     = 1'b0;
               state_d    = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset discards any op in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         cnt_q      <= '0;
         opnd_q     <= '0;
         mcand_q    <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         carry_q    <= 1'b0;
         less_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         opnd_q     <= opnd_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         carry_q    <= carry_d;
         less_q     <= less_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq at WIDTH=8 with a behavioural
//               reference model, directed cases and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   localparam int WIDTH = 8;

   typedef struct {
      logic [7:0] r;
      logic       z;
      logic       v;
      logic       c;
      logic       l;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero;
   logic       overflow;
   logic       carry;
   logic       less;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t cur_exp;
   logic exp_pending = 1'b0;

   alu_seq #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .carry     (carry),
      .less      (less)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: what the op must produce, from plain arithmetic.
   function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                  input logic [7:0] y, input logic ci);
      exp_t e;
      int   s;
      int   u;
      int   amt;
      amt   = int'(y[2:0]);
      e.r   = 8'h00;
      e.z   = 1'b0;
      e.v   = 1'b0;
      e.c   = 1'b0;
      e.l   = 1'b0;
      e.lat = 1;
      case (o)
         4'd0: begin
            u   = int'(x) + int'(y) + int'(ci);
            s   = int'($signed(x)) + int'($signed(y)) + int'(ci);
            e.r = u[7:0];
            e.c = (u > 255);
            e.v = (s > 127) || (s < -128);
         end
         4'd1: begin
            u   = int'(x) - int'(y);
            s   = int'($signed(x)) - int'($signed(y));
            e.r = u[7:0];
            e.c = (x >= y);
            e.v = (s > 127) || (s < -128);
            e.l = ($signed(x) < $signed(y));
         end
         4'd2: e.r = ~x;
         4'd3: e.r = x & y;
         4'd4: e.r = x | y;
         4'd5: e.r = x ^ y;
         4'd6: begin e.l = ($signed(x) < $signed(y)); e.r = {7'd0, e.l}; end
         4'd7: begin e.l = (x == y); e.r = {7'd0, e.l}; end
         4'd8: begin e.l = (x < y); e.r = {7'd0, e.l}; end
         4'd9:  begin e.r = x << amt; e.lat = amt + 1; end
         4'd10: begin e.r = x >> amt; e.lat = amt + 1; end
         4'd11: begin e.r = $signed(x) >>> amt; e.lat = amt + 1; end
         4'd12: begin
            u     = int'(x) * int'(y);
            e.r   = u[7:0];
            e.lat = WIDTH + 1;
         end
         default: ;
      endcase
      if (o <= 4'd12) e.z = (e.r == 8'h00);
      return e;
   endfunction

   // Compare process: every DONE cycle must show the pending expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1) begin
         if (!exp_pending) begin
            check("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
         end else begin
            check("result",   {24'd0, result},   {24'd0, cur_exp.r});
            check("zero",     {31'd0, zero},     {31'd0, cur_exp.z});
            check("overflow", {31'd0, overflow}, {31'd0, cur_exp.v});
            check("carry",    {31'd0, carry},    {31'd0, cur_exp.c});
            check("less",     {31'd0, less},     {31'd0, cur_exp.l});
            check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
         end
      end
   end

   task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input int hold);
      exp_t m;
      int   g;
      int   lat;
      m = model(o, x, y, ci);
      @(negedge clk);
      op = o; a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
      g = 0;
      while (in_ready !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      cur_exp = m;
      @(posedge clk);
      exp_pending = 1'b1;
      #1;
      // Keep presenting a different op; it must be ignored until IDLE.
      op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (out_valid !== 1'b1 && lat < 40);
      check("latency", lat, m.lat);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      exp_pending = 1'b0;
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_handshake",  {31'd0, in_ready},  32'd1);
   endtask

   task automatic pin(input string name, input logic [3:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic ci, input logic [7:0] r,
                      input logic [3:0] zvcl, input int lat);
      exp_t m;
      m = model(o, x, y, ci);
      check({name, "_model_r"},    {24'd0, m.r}, {24'd0, r});
      check({name, "_model_zvcl"}, {28'd0, m.z, m.v, m.c, m.l}, {28'd0, zvcl});
      check({name, "_model_lat"},  m.lat, lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = 4'd0; a = 8'd0; b = 8'd0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("in_ready_during_reset", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result",    {24'd0, result},    32'd0);
      check("reset_flags",     {28'd0, zero, overflow, carry, less}, 32'd0);
      check("reset_in_ready",  {31'd0, in_ready},  32'd1);

      // Hand-computed literals pinning the model (flags order z,v,c,l).
      pin("add_7f_01",  4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b0100, 1);
      pin("sub_05_05",  4'd1,  8'h05, 8'h05, 1'b0, 8'h00, 4'b1010, 1);
      pin("slt_fe_01",  4'd6,  8'hFE, 8'h01, 1'b0, 8'h01, 4'b0001, 1);
      pin("sltu_fe_01", 4'd8,  8'hFE, 8'h01, 1'b0, 8'h00, 4'b1000, 1);
      pin("sra_80_3",   4'd11, 8'h80, 8'h03, 1'b0, 8'hF0, 4'b0000, 4);
      pin("srl_80_7",   4'd10, 8'h80, 8'h07, 1'b0, 8'h01, 4'b0000, 8);
      pin("mul_13_11",  4'd12, 8'd13, 8'd11, 1'b0, 8'h8F, 4'b0000, 9);
      pin("mul_16_16",  4'd12, 8'd16, 8'd16, 1'b0, 8'h00, 4'b1000, 9);
      pin("illegal_14", 4'd14, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0000, 1);

      // Directed cases through the DUT.
      run_op(4'd0,  8'h7F, 8'h01, 1'b0, 0);
      run_op(4'd1,  8'h05, 8'h05, 1'b0, 0);
      run_op(4'd6,  8'hFE, 8'h01, 1'b0, 0);
      run_op(4'd8,  8'hFE, 8'h01, 1'b0, 0);
      run_op(4'd11, 8'h80, 8'h03, 1'b0, 0);
      run_op(4'd9,  8'h5A, 8'h00, 1'b0, 0);
      run_op(4'd10, 8'h80, 8'h07, 1'b0, 0);
      run_op(4'd12, 8'd13, 8'd11, 1'b0, 0);
      run_op(4'd12, 8'd16, 8'd16, 1'b0, 0);
      run_op(4'd7,  8'h33, 8'h33, 1'b0, 5);   // backpressure in DONE
      run_op(4'd15, 8'hFF, 8'h00, 1'b1, 2);   // illegal code
      run_op(4'd0,  8'hFF, 8'h00, 1'b1, 0);   // carry out with cin

      // Reset at the 4th BUSY cycle of a MUL aborts it.
      @(negedge clk);
      op = 4'd12; a = 8'd13; b = 8'd11; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_result",    {24'd0, result},    32'd0);
      check("abort_in_ready",  {31'd0, in_ready},  32'd1);
      repeat (15) @(negedge clk);   // compare process flags any stale result

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                1'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle ALU. It replaces the fixed 4-bit combinational ALU with a WIDTH-bit datapath and valid/ready handshakes on both sides. The op set adds unsigned compare, iterative shifts (one bit per cycle) and an iterative shift-add multiplier. It sits between operand fetch and writeback in the npc execute stage; results and flags are registered and held until consumed.

## Interface
- WIDTH, 32, datapath width; power of two, ≥4. SW = $clog2(WIDTH).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept; equals (state==IDLE) && !rst
- op  in  4  operation code (see Operation)
- a, b  in  WIDTH  operands
- cin  in  1  carry-in, used by ADD only
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero, overflow, carry, less  out  1 each  registered flags

## Operation
- Accept when in_valid && in_ready at a rising edge; op, a, b and cin are captured at that edge.
- Op codes:
  - 0 ADD: a+b+cin
  - 1 SUB: a+~b+1
  - 2 NOT: ~a
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLT: signed a<b, result {0..,lt}
  - 7 EQ: result {0..,a==b}
  - 8 SLTU: unsigned a<b
  - 9 SLL, 10 SRL, 11 SRA: shift amount b[SW-1:0]
  - 12 MUL: low WIDTH bits of a*b, unsigned
  - 13–15: illegal; result 0, all flags 0, single-cycle timing.
- Flags:
  - zero = (result==0) for all legal ops.
  - carry = carry-out for ADD. For SUB, carry = carry-out of a+~b+1, where 1 means no borrow. carry = 0 otherwise.
  - overflow = signed overflow for ADD/SUB (operand signs as seen by the adder agree, result sign differs). overflow = 0 otherwise.
  - less = signed a<b for SLT/SUB and unsigned a<b for SLTU. less = (a==b) for EQ. less = 0 otherwise.
- FSM states and transitions:
  - IDLE: on accept, single-cycle op → DONE; shift with amount 0 → DONE; shift with amount > 0 → BUSY (cnt=amount); MUL → BUSY (cnt=WIDTH, acc=0).
  - BUSY, shifts: shift the operand register by 1 per edge (SRA replicates the MSB) and decrement cnt. When cnt reaches 1, the edge writes the final result → DONE.
  - BUSY, MUL: if mcand LSB is set, add mplier into acc. Then shift mplier left and mcand right, and decrement cnt. At cnt==1 → DONE.
  - DONE: out_valid=1. out_valid && out_ready → IDLE.
- in_ready is 0 in BUSY and DONE. in_valid is ignored there; no queuing.
- result and flags change only on the edge entering DONE. They are stable for the whole of DONE.

## Timing
- Latency is counted from the accept edge to the first cycle with out_valid=1:
  - single-cycle ops, illegal ops and zero-amount shifts: 1 cycle
  - shifts: amount+1 cycles
  - MUL: WIDTH+1 cycles
- Throughput: minimum 2 cycles per op (DONE → IDLE → accept).
- Reset values: state IDLE, out_valid 0, result 0, zero/overflow/carry/less 0, cnt 0. in_ready is 0 while rst=1 and 1 on the first cycle after.
- Reset mid-BUSY or mid-DONE aborts the op. The result is discarded and never presented.
- Backpressure: with out_ready=0, DONE holds indefinitely and all outputs are frozen.
- Maximum shift amount is WIDTH-1; bits of b above SW-1 are ignored.

## Structure
- Package alu_pkg holds:
  - op code localparams/enum (ALU_ADD..ALU_MUL)
  - FSM state enum (IDLE, BUSY, DONE)
- Sub-module alu_core: purely combinational WIDTH-bit single-cycle ops plus flag generation, shared by ADD/SUB/logic/compare.
- alu_seq holds the FSM, the cnt counter, the shift/multiply iteration registers and the output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD a=8'h7F, b=8'h01, cin=0 → result 8'h80, overflow=1, carry=0, zero=0; out_valid one cycle after accept.
- SUB a=8'h05, b=8'h05 → result 0, zero=1, carry=1, less=0. SLT a=8'hFE, b=8'h01 → result 1. SLTU with the same operands → result 0.
- SRA a=8'h80, b=3 → 8'hF0 after 4 cycles. SLL with b=0 → a after 1 cycle. SRL 8'h80 by 7 → 8'h01 after 8 cycles.
- MUL 13×11 → 8'h8F, carry=overflow=0, after 9 cycles. MUL 16×16 → 0 with zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with a new op. result stays frozen and in_ready stays 0; after the handshake the new op is accepted only from IDLE.
- Assert rst for one cycle at the 4th BUSY cycle of a MUL → next cycle out_valid=0, result=0, in_ready=1, and no stale result appears afterwards.
